// File: rtl/cpu_ctrl.sv
// Instruction register, decoder and Moore sequencer for the 16-bit datapath.
// Outputs are a pure function of the current state and the latched instruction.
module cpu_ctrl #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s,
   input  logic              load,
   input  logic [DATA_W-1:0] in,
   output logic              w,
   output logic [2:0]        readnum,
   output logic [2:0]        writenum,
   output logic              write,
   output logic [1:0]        vsel,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        ALUop,
   output logic [1:0]        shift,
   output logic [DATA_W-1:0] sximm8,
   output logic [DATA_W-1:0] sximm5
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_RD, S_WR_IMM
   } state_t;

   state_t            r_state, w_nxt;
   logic [DATA_W-1:0] r_ir;

   logic [2:0] w_opc, w_rn, w_rd, w_rm;
   logic [1:0] w_op, w_sh;
   logic       w_movi, w_movr, w_alu, w_cmp, w_mvn;

   assign w_opc = r_ir[15:13];
   assign w_op  = r_ir[12:11];
   assign w_rn  = r_ir[10:8];
   assign w_rd  = r_ir[7:5];
   assign w_sh  = r_ir[4:3];
   assign w_rm  = r_ir[2:0];

   assign w_movi = (w_opc == 3'b110) && (w_op == 2'b10);
   assign w_movr = (w_opc == 3'b110) && (w_op == 2'b00);
   assign w_alu  = (w_opc == 3'b101);
   assign w_cmp  = w_alu && (w_op == 2'b01);
   assign w_mvn  = w_alu && (w_op == 2'b11);

   assign sximm8 = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
   assign sximm5 = {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};

   // IR only accepts a new word while idle, so it is stable for a whole instruction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_WAIT;
         r_ir    <= '0;
      end else begin
         r_state <= w_nxt;
         if (r_state == S_WAIT && load) r_ir <= in;
      end
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_WAIT:   if (s) w_nxt = S_DECODE;
         S_DECODE: begin
            if (w_movi)                 w_nxt = S_WR_IMM;
            else if (w_movr || w_mvn)   w_nxt = S_GET_B;
            else if (w_alu)             w_nxt = S_GET_A;
            else                        w_nxt = S_WAIT;
         end
         S_GET_A:  w_nxt = S_GET_B;
         S_GET_B:  w_nxt = S_ALU;
         S_ALU:    w_nxt = w_cmp ? S_WAIT : S_WR_RD;
         S_WR_RD:  w_nxt = S_WAIT;
         S_WR_IMM: w_nxt = S_WAIT;
         default:  w_nxt = S_WAIT;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      write    = 1'b0;
      vsel     = 2'b00;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      ALUop    = 2'b00;
      shift    = 2'b00;
      case (r_state)
         S_WAIT:  w = 1'b1;
         S_GET_A: begin
            readnum = w_rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = w_rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            shift = w_sh;
            ALUop = w_op;
            // MOV-reg rides the adder with A forced to zero
            asel  = w_movr;
            loads = w_cmp;
            loadc = !w_cmp;
         end
         S_WR_RD: begin
            readnum  = w_rd;
            writenum = w_rd;
            write    = 1'b1;
         end
         S_WR_IMM: begin
            readnum  = w_rn;
            writenum = w_rn;
            vsel     = 2'b10;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
